// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI phase sequencer: the FSM state encoding
// (which doubles as the phase output), the lane-mode enum, phase constants,
// the latched transaction configuration and a data-phase length helper.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } qspi_state_e;

    typedef enum logic {
        LANE_X1 = 1'b0,
        LANE_X4 = 1'b1
    } qspi_lane_e;

    // Longest phase is 15 bytes on one lane = 120 cycles, so 7 bits suffice.
    localparam int         CNT_W      = 7;
    localparam logic [6:0] CMD_CYCLES = 7'd8;

    typedef struct packed {
        logic       addr_en;
        qspi_lane_e addr_lane;
        qspi_lane_e data_lane;
        logic [4:0] dummy;
        logic [3:0] data_bytes;
    } qspi_cfg_t;

    // Clock cycles needed to move the data bytes: 2 per byte on 4 lanes,
    // 8 per byte on 1 lane.
    function automatic logic [CNT_W-1:0] data_cycles(input qspi_lane_e lane,
                                                     input logic [3:0] bytes);
        return (lane == LANE_X4) ? {2'b00, bytes, 1'b0} : {bytes, 3'b000};
    endfunction

endpackage

// File: rtl/qspi_phase_timer.sv
// Phase length timer: loaded with a phase length on every phase entry, then
// counts cycles and flags the final cycle of the phase. A length of zero
// (IDLE/DONE) keeps the counter parked at zero with last deasserted.
module qspi_phase_timer
    import qspi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;

    assign last = (len_q != '0) && (cnt_q == len_q - 7'd1);

    // Restart on load; otherwise advance until the final cycle is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
            len_q <= len;
        end else if (!last && (len_q != '0)) begin
            cnt_q <= cnt_q + 7'd1;
        end
    end

endmodule

// File: rtl/qspi_phase_sequencer.sv
// QSPI transaction phase sequencer: walks CMD -> ADDR -> DUMMY -> DATA -> DONE,
// skipping any phase whose length is zero, and drives chip select, lane mode
// and shift enables for a downstream serializer.
// Optional feature macro: QSPI_DUMMY_PHASE_EN enables the DUMMY phase; when it
// is undefined cfg_dummy is ignored and DUMMY is never entered.
module qspi_phase_sequencer
    import qspi_pkg::*;
#(
    parameter int ADDR_BITS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       ready,
    input  logic       abort,
    input  logic       cfg_addr_en,
    input  logic       cfg_addr_quad,
    input  logic       cfg_data_quad,
    input  logic [4:0] cfg_dummy,
    input  logic [3:0] cfg_data_bytes,
    output logic       cs_n,
    output logic [2:0] phase,
    output logic       quad_mode,
    output logic       shift_en,
    output logic       phase_last,
    output logic       done
);

    localparam logic [CNT_W-1:0] ADDR_X1_CYCLES = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] ADDR_X4_CYCLES = CNT_W'(ADDR_BITS / 4);

    qspi_state_e      state_q;
    qspi_state_e      state_d;
    qspi_cfg_t        cfg_q;
    logic [CNT_W-1:0] addr_len;
    logic [CNT_W-1:0] dummy_len;
    logic [CNT_W-1:0] data_len;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_len;
    logic             tmr_last;
    logic             active;

    // Configuration is captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            cfg_q.addr_en    <= cfg_addr_en;
            cfg_q.addr_lane  <= qspi_lane_e'(cfg_addr_quad);
            cfg_q.data_lane  <= qspi_lane_e'(cfg_data_quad);
            cfg_q.dummy      <= cfg_dummy;
            cfg_q.data_bytes <= cfg_data_bytes;
        end
    end

`ifdef QSPI_DUMMY_PHASE_EN
    assign dummy_len = {2'b00, cfg_q.dummy};
`else
    logic unused_dummy;
    assign unused_dummy = ^cfg_q.dummy;
    assign dummy_len    = '0;
`endif

    // Phase lengths derived from the latched configuration.
    always_comb begin
        addr_len = '0;
        if (cfg_q.addr_en) begin
            addr_len = (cfg_q.addr_lane == LANE_X4) ? ADDR_X4_CYCLES : ADDR_X1_CYCLES;
        end
        data_len = data_cycles(cfg_q.data_lane, cfg_q.data_bytes);
    end

    // Next-state logic: each phase hands over to the next non-empty phase on
    // its final cycle; abort returns any busy state straight to IDLE.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_len  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CMD;
                    tmr_load = 1'b1;
                    tmr_len  = CMD_CYCLES;
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end else if (tmr_last) begin
                    tmr_load = 1'b1;
                    if ((state_q == ST_CMD) && (addr_len != '0)) begin
                        state_d = ST_ADDR;
                        tmr_len = addr_len;
                    end else if (((state_q == ST_CMD) || (state_q == ST_ADDR)) &&
                                 (dummy_len != '0)) begin
                        state_d = ST_DUMMY;
                        tmr_len = dummy_len;
                    end else if ((state_q != ST_DATA) && (data_len != '0)) begin
                        state_d = ST_DATA;
                        tmr_len = data_len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                tmr_load = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                tmr_load = 1'b1;
            end
        endcase
    end

    // State register; reset outranks start and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    qspi_phase_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (tmr_len),
        .last (tmr_last)
    );

    // Output decode, purely from the current state and latched lane modes.
    always_comb begin
        active     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DUMMY) || (state_q == ST_DATA);
        ready      = (state_q == ST_IDLE);
        cs_n       = !active;
        phase      = state_q;
        shift_en   = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
        phase_last = active && tmr_last;
        done       = (state_q == ST_DONE);
        quad_mode  = 1'b0;
        if (state_q == ST_ADDR) begin
            quad_mode = cfg_q.addr_lane;
        end else if (state_q == ST_DATA) begin
            quad_mode = cfg_q.data_lane;
        end
    end

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// Testbench for qspi_phase_sequencer. The reference model lays out the
// expected per-cycle output vector of a transaction from the phase lengths.
module tb_qspi_phase_sequencer;

    localparam int AB = 24;
`ifdef QSPI_DUMMY_PHASE_EN
    localparam bit DUMMY_EN = 1'b1;
`else
    localparam bit DUMMY_EN = 1'b0;
`endif

    typedef logic [8:0] vec_t;   // {ready, cs_n, phase[2:0], quad, shift, last, done}
    typedef vec_t vec_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic       abort = 1'b0;
    logic       cfg_addr_en = 1'b0;
    logic       cfg_addr_quad = 1'b0;
    logic       cfg_data_quad = 1'b0;
    logic [4:0] cfg_dummy = '0;
    logic [3:0] cfg_data_bytes = '0;
    logic       cs_n;
    logic [2:0] phase;
    logic       quad_mode;
    logic       shift_en;
    logic       phase_last;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    qspi_phase_sequencer #(.ADDR_BITS(AB)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ready          (ready),
        .abort          (abort),
        .cfg_addr_en    (cfg_addr_en),
        .cfg_addr_quad  (cfg_addr_quad),
        .cfg_data_quad  (cfg_data_quad),
        .cfg_dummy      (cfg_dummy),
        .cfg_data_bytes (cfg_data_bytes),
        .cs_n           (cs_n),
        .phase          (phase),
        .quad_mode      (quad_mode),
        .shift_en       (shift_en),
        .phase_last     (phase_last),
        .done           (done)
    );

    function automatic vec_t mk(bit rdy, bit csn, int ph, bit q, bit sh, bit lst, bit dn);
        return {rdy, csn, 3'(ph), q, sh, lst, dn};
    endfunction

    function automatic vec_t observe();
        return {ready, cs_n, phase, quad_mode, shift_en, phase_last, done};
    endfunction

    localparam vec_t IDLE_V = 9'b1_1_000_0_0_0_0;

    // Expected outputs for every cycle after acceptance, through the first
    // IDLE cycle. cut_at >= 0 models abort/reset taking effect after that
    // cycle index.
    task automatic model(input bit ae, input bit aq, input bit dq, input int dmy,
                         input int bytes, input int cut_at, output vec_q_t q);
        int len[4];
        bit qd[4];
        bit sh[4];
        q = {};
        len[0] = 8;
        len[1] = ae ? (aq ? AB / 4 : AB) : 0;
        len[2] = DUMMY_EN ? dmy : 0;
        len[3] = dq ? 2 * bytes : 8 * bytes;
        qd[0] = 1'b0; qd[1] = aq;   qd[2] = 1'b0; qd[3] = dq;
        sh[0] = 1'b1; sh[1] = 1'b1; sh[2] = 1'b0; sh[3] = 1'b1;
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < len[p]; j++)
                q.push_back(mk(0, 0, p + 1, qd[p], sh[p], j == len[p] - 1, 0));
        q.push_back(mk(0, 1, 5, 0, 0, 0, 1));
        if (cut_at >= 0)
            while (q.size() > cut_at + 1) void'(q.pop_back());
        q.push_back(IDLE_V);
    endtask

    // Called at a negedge with the DUT idle: requests a transaction, then
    // samples n cycles. Config inputs are scrambled after acceptance.
    task automatic drive(input bit ae, input bit aq, input bit dq, input int dmy,
                         input int bytes, input bit hold, input bit abort_first,
                         input int abort_at, input int rst_at, input int n,
                         output vec_q_t obs);
        obs = {};
        cfg_addr_en    = ae;
        cfg_addr_quad  = aq;
        cfg_data_quad  = dq;
        cfg_dummy      = 5'(dmy);
        cfg_data_bytes = 4'(bytes);
        start = 1'b1;
        abort = abort_first;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs.push_back(observe());
            start = hold && (i < n - 1);
            abort = (i == abort_at);
            rst   = (i == rst_at);
            cfg_addr_en    = 1'($urandom);
            cfg_addr_quad  = 1'($urandom);
            cfg_data_quad  = 1'($urandom);
            cfg_dummy      = 5'($urandom);
            cfg_data_bytes = 4'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        vec_t o;
        start = 1'b1;
        repeat (3) @(negedge clk);
        o = observe();
        vectors++;
        if (o !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_held: got %b expected %b", o, IDLE_V);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        o = observe();
        vectors++;
        if (o !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", o, IDLE_V);
        end
    endtask

    task automatic test_single_read();
        vec_q_t e, o;
        model(1, 0, 0, 0, 1, -1, e);
        drive(1, 0, 0, 0, 1, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL single_read cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
        // Counting the accept cycle as cycle 1, done appears in cycle 42.
        vectors++;
        if (o[40][0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_read_done_cycle42: got done=%b expected 1", o[40][0]);
        end
    endtask

    task automatic test_quad_fast_read();
        vec_q_t e, o;
        model(1, 1, 1, 6, 4, -1, e);
        drive(1, 1, 1, 6, 4, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL quad_fast_read cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    task automatic test_cmd_only();
        vec_q_t e, o;
        model(0, 1, 1, 0, 0, -1, e);
        drive(0, 1, 1, 0, 0, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL cmd_only cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    task automatic test_max_lengths();
        vec_q_t e, o;
        model(1, 0, 0, 31, 15, -1, e);
        drive(1, 0, 0, 31, 15, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL max_lengths cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    // Abort on the third DATA cycle, then a fresh start in the IDLE cycle.
    task automatic test_abort();
        vec_q_t e, o;
        int cut;
        cut = 8 + AB / 4 + (DUMMY_EN ? 3 : 0) + 2;
        model(1, 1, 1, 3, 4, cut, e);
        drive(1, 1, 1, 3, 4, 0, 0, cut, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL abort_data cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
        model(0, 0, 1, 0, 2, -1, e);
        drive(0, 0, 1, 0, 2, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL after_abort cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    task automatic test_cfg_hold();
        vec_q_t e, o;
        model(1, 0, 1, 5, 3, -1, e);
        drive(1, 0, 1, 5, 3, 1, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL start_held cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    // Reset four cycles into ADDR; dummy=6 also exercises the DUMMY build option.
    task automatic test_reset_mid();
        vec_q_t e, o;
        model(1, 0, 0, 6, 2, 11, e);
        drive(1, 0, 0, 6, 2, 0, 0, -1, 11, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
        model(1, 1, 0, 6, 1, -1, e);
        drive(1, 1, 0, 6, 1, 0, 0, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL dummy6 cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    task automatic test_idle_abort();
        vec_q_t e, o;
        vec_t v;
        abort = 1'b1;
        @(negedge clk);
        v = observe();
        abort = 1'b0;
        vectors++;
        if (v !== IDLE_V) begin
            miscompares++;
            $display("FAIL idle_abort: got %b expected %b", v, IDLE_V);
        end
        model(1, 1, 0, 2, 1, -1, e);
        drive(1, 1, 0, 2, 1, 0, 1, -1, -1, e.size(), o);
        for (int i = 0; i < e.size(); i++) begin
            vectors++;
            if (o[i] !== e[i]) begin
                miscompares++;
                $display("FAIL start_with_abort cyc %0d: got %b expected %b", i, o[i], e[i]);
            end
        end
    endtask

    // Randomized back-to-back transactions, some aborted part way.
    task automatic test_back_to_back();
        vec_q_t e, o;
        bit ae, aq, dq, hold;
        int dmy, bytes, cut;
        for (int t = 0; t < 30; t++) begin
            ae = 1'($urandom); aq = 1'($urandom); dq = 1'($urandom);
            hold = 1'($urandom);
            dmy = $urandom_range(0, 31);
            bytes = $urandom_range(0, 15);
            cut = -1;
            model(ae, aq, dq, dmy, bytes, -1, e);
            if (!hold && ($urandom_range(0, 3) == 0))
                cut = $urandom_range(0, e.size() - 3);
            model(ae, aq, dq, dmy, bytes, cut, e);
            drive(ae, aq, dq, dmy, bytes, hold, 0, cut, -1, e.size(), o);
            for (int i = 0; i < e.size(); i++) begin
                vectors++;
                if (o[i] !== e[i]) begin
                    miscompares++;
                    $display("FAIL random t%0d cyc %0d: got %b expected %b", t, i, o[i], e[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_quad_fast_read();
        test_cmd_only();
        test_max_lengths();
        test_abort();
        test_cfg_hold();
        test_reset_mid();
        test_idle_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
